// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register scoreboard for an in-order pipeline.
// Each architectural register (8 of them) carries a 3-bit stage tag that
// holds the pipeline stage (1..4) of its youngest pending write. A tag of 0
// means the register file holds the current value.
//
// Configuration macro SCOREBOARD_FWD_EN:
//    defined   - a tag of 4 (WB) is served by the write-data bypass, so only
//                tags 1..3 cause a read hazard.
//    undefined - a read waits until the tag returns to 0 (tags 1..4 stall).
module reg_scoreboard (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        issue_valid,
   input  logic        issue_we,
   input  logic [2:0]  issue_wr,
   input  logic        src1_use,
   input  logic        src2_use,
   input  logic [2:0]  src1,
   input  logic [2:0]  src2,
   input  logic        flush,
   output logic        stall,
   output logic [2:0]  register_invalid [8],
   output logic        busy,
   output logic [15:0] stall_cnt
);

`ifdef SCOREBOARD_FWD_EN
   localparam logic [2:0] HAZ_MAX = 3'd3;
`else
   localparam logic [2:0] HAZ_MAX = 3'd4;
`endif

   logic [7:0][2:0] tag_reg;
   logic [7:0][2:0] tag_next;
   logic [15:0]     stall_cnt_reg;
   logic            hazard1;
   logic            hazard2;
   logic            accept;

   // Hazard detection, stall and accept decode from the current tags
   always_comb begin
      hazard1 = src1_use && (tag_reg[src1] != 3'd0) && (tag_reg[src1] <= HAZ_MAX);
      hazard2 = src2_use && (tag_reg[src2] != 3'd0) && (tag_reg[src2] <= HAZ_MAX);
      stall   = issue_valid && !flush && (hazard1 || hazard2);
      accept  = en && issue_valid && !stall && !flush;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_tag
         // Per-register next tag: advance/wrap, flush squash, issue override
         always_comb begin
            tag_next[gi] = tag_reg[gi];
            if (flush && (tag_reg[gi] == 3'd1 || tag_reg[gi] == 3'd2))
               tag_next[gi] = 3'd0;
            else if (tag_reg[gi] == 3'd4)
               tag_next[gi] = 3'd0;
            else if (tag_reg[gi] != 3'd0)
               tag_next[gi] = tag_reg[gi] + 3'd1;
            // A newly accepted writer always becomes the youngest
            if (accept && issue_we && (issue_wr == 3'(gi)))
               tag_next[gi] = 3'd1;
         end

         assign register_invalid[gi] = tag_reg[gi];
      end
   endgenerate

   // Tag state: cleared by reset, otherwise updated only while en is high
   always_ff @(posedge clk) begin
      if (reset)
         tag_reg <= '0;
      else if (en)
         tag_reg <= tag_next;
   end

   // Saturating count of cycles where decode was held
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt_reg <= 16'd0;
      else if (en && stall && (stall_cnt_reg != 16'hFFFF))
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
   end

   assign busy      = |tag_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed scenarios, randomized traffic
// and a stall-counter saturation run, all checked against a behavioural
// model. Expectations are queued by the driver and popped by a monitor.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_FWD_EN
   localparam int HAZ_MAX = 3;
`else
   localparam int HAZ_MAX = 4;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_we = 1'b0;
   logic [2:0]  issue_wr = 3'd0;
   logic        src1_use = 1'b0;
   logic        src2_use = 1'b0;
   logic [2:0]  src1 = 3'd0;
   logic [2:0]  src2 = 3'd0;
   logic        flush = 1'b0;
   logic        stall;
   logic [2:0]  register_invalid [8];
   logic        busy;
   logic [15:0] stall_cnt;

   reg_scoreboard dut (
      .clk              (clk),
      .reset            (reset),
      .en               (en),
      .issue_valid      (issue_valid),
      .issue_we         (issue_we),
      .issue_wr         (issue_wr),
      .src1_use         (src1_use),
      .src2_use         (src2_use),
      .src1             (src1),
      .src2             (src2),
      .flush            (flush),
      .stall            (stall),
      .register_invalid (register_invalid),
      .busy             (busy),
      .stall_cnt        (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] tags;
      logic        busy;
      logic [15:0] cnt;
      logic        stall;
      bit          chk_state;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_no   = 0;
   bit push_on  = 1'b1;
   bit driving_done = 1'b0;

   // Behavioural model: per-register stage of youngest pending write
   int m_stage [8];
   int m_cnt;
   bit m_known = 1'b0;

   function automatic bit m_hazard(input bit use_it, input int r);
      return use_it && (m_stage[r] >= 1) && (m_stage[r] <= HAZ_MAX);
   endfunction

   task automatic cycle(input bit rst, input bit e, input bit iv, input bit we,
                        input int wr, input bit u1, input int s1,
                        input bit u2, input int s2, input bit fl);
      exp_t x;
      bit   st;
      int   nxt [8];
      @(posedge clk);
      #2;
      reset = rst; en = e; issue_valid = iv; issue_we = we;
      issue_wr = 3'(wr); src1_use = u1; src1 = 3'(s1);
      src2_use = u2; src2 = 3'(s2); flush = fl;
      cyc_no++;
      st = iv && !fl && (m_hazard(u1, s1) || m_hazard(u2, s2));
      x.tags = '0;
      x.busy = 1'b0;
      for (int r = 0; r < 8; r++) begin
         x.tags[r*3 +: 3] = 3'(m_stage[r]);
         if (m_stage[r] != 0) x.busy = 1'b1;
      end
      x.cnt = 16'(m_cnt);
      x.stall = st;
      x.chk_state = m_known;
      x.cyc = cyc_no;
      if (push_on) exp_q.push_back(x);
      // model update for the coming edge
      if (rst) begin
         for (int r = 0; r < 8; r++) m_stage[r] = 0;
         m_cnt = 0;
         m_known = 1'b1;
      end else if (e) begin
         if (st && m_cnt < 65535) m_cnt = m_cnt + 1;
         for (int r = 0; r < 8; r++) begin
            if (fl && (m_stage[r] == 1 || m_stage[r] == 2)) nxt[r] = 0;
            else if (m_stage[r] != 0) nxt[r] = (m_stage[r] + 1) % 5;
            else nxt[r] = 0;
         end
         if (iv && !st && !fl && we) nxt[wr] = 1;
         for (int r = 0; r < 8; r++) m_stage[r] = nxt[r];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic issue_w(input int wr);
      cycle(0, 1, 1, 1, wr, 0, 0, 0, 0, 0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
   endtask

   // Monitor: compares DUT outputs with queued expectations mid-cycle
   initial begin : monitor
      exp_t x;
      logic [23:0] act_tags;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            for (int r = 0; r < 8; r++) act_tags[r*3 +: 3] = register_invalid[r];
            check("stall", 32'(stall), 32'(x.stall), x.cyc);
            if (x.chk_state) begin
               check("tags", 32'(act_tags), 32'(x.tags), x.cyc);
               check("busy", 32'(busy), 32'(x.busy), x.cyc);
               check("stall_cnt", 32'(stall_cnt), 32'(x.cnt), x.cyc);
            end
         end
      end
   end

   // Driver: directed scenarios, random traffic, saturation
   initial begin : driver
      int extra;
      for (int r = 0; r < 8; r++) m_stage[r] = 0;
      m_cnt = 0;
      do_reset();
      do_reset();

      // back-to-back dependency on r3
      issue_w(3);
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0, 1, 3, 0, 0, 0);
      idle(2);

      // advance and wrap of r5
      do_reset();
      issue_w(5);
      idle(6);

      // flush: r4=3, r2=2, r1=1, then flush with a write of r6
      issue_w(4);
      issue_w(2);
      issue_w(1);
      cycle(0, 1, 1, 1, 6, 0, 0, 0, 0, 1);
      idle(3);

      // en hold with a stalling reader of r2
      issue_w(2);
      idle(1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 1, 2, 0, 0, 0);
      idle(1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // flush with en=0 does nothing
      idle(4);

      // rewrite then reset
      issue_w(7);
      idle(2);
      issue_w(7);
      cycle(1, 1, 1, 1, 3, 1, 7, 1, 7, 1);
      cycle(0, 1, 0, 0, 0, 1, 7, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(63) == 0), ($urandom_range(9) < 8),
               ($urandom_range(3) != 0), $urandom_range(1), $urandom_range(7),
               $urandom_range(1), $urandom_range(7), $urandom_range(1),
               $urandom_range(7), ($urandom_range(7) == 0));
      end

      // saturation: self-dependent writer of r3 keeps decode stalled
      do_reset();
      push_on = 1'b0;
      extra = 0;
      while (m_cnt < 65535 || extra < 40) begin
         if (m_cnt == 65535) extra++;
         cycle(0, 1, 1, 1, 3, 1, 3, 0, 0, 0);
      end
      push_on = 1'b1;
      for (int i = 0; i < 12; i++) cycle(0, 1, 1, 1, 3, 1, 3, 0, 0, 0);
      idle(2);
      do_reset();
      idle(1);

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
